// File: rtl/jardim_eventos.sv
// Dawn/dusk/manual event source for the irrigation controller: request low one edge after the event, acked via irrigando, re-sent on timeout.
// Optional rain gate on scheduled events when JARDIM_EVT_CHUVA_EN is defined (adds input chuva).
module jardim_eventos #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int DAY_LEN       = 24,
  parameter int DAWN_AT       = 6,
  parameter int DUSK_AT       = 18,
  parameter int PULSE_LEN     = 3,
  parameter int ACK_TIMEOUT   = 100,
  parameter int MAX_RETRY     = 2,
  parameter int DEBOUNCE      = 1000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic botao_n,
  input  logic irrigando,
`ifdef JARDIM_EVT_CHUVA_EN
  input  logic chuva,
`endif
  output logic amanhecer_n,
  output logic anoitecer_n,
  output logic controle_n,
  output logic dia,
  output logic falha
);
  localparam int CW      = $clog2(TICKS_PER_SEC + 1);
  localparam int SW      = $clog2(DAY_LEN + 1);
  localparam int DW      = $clog2(DEBOUNCE + 1);
  localparam int CNT_MAX = (PULSE_LEN > ACK_TIMEOUT) ? PULSE_LEN : ACK_TIMEOUT;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {OCIOSO, PULSO, ESPERA} estado_t;

  logic [CW-1:0] r_ciclo;
  logic [SW-1:0] r_seg;
  logic          r_dia;
  logic          r_btn_s1, r_btn_s2, r_btn_f;
  logic [DW-1:0] r_db_cnt;
  estado_t       r_est;
  logic [2:0]    r_pend, r_sel;  // bit 0 dawn, bit 1 dusk, bit 2 manual
  logic [TW-1:0] r_cnt;
  logic [RW-1:0] r_try;
  logic          r_irr0, r_am_n, r_an_n, r_ct_n, r_falha;

  logic          w_wrap, w_sched_ok, w_ev_man, w_drop, w_ack, w_tmo, w_done, w_plen_end;
  logic [SW-1:0] w_seg_nxt;
  logic [2:0]    w_set, w_pick, w_clr;

`ifdef JARDIM_EVT_CHUVA_EN
  logic r_chuva_s1, r_chuva_s2;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_chuva_s1 <= 1'b0;
      r_chuva_s2 <= 1'b0;
    end else begin
      r_chuva_s1 <= chuva;
      r_chuva_s2 <= r_chuva_s1;
    end
  end

  assign w_sched_ok = ~r_chuva_s2;
`else
  assign w_sched_ok = 1'b1;
`endif

  assign w_wrap    = (r_ciclo == CW'(TICKS_PER_SEC - 1));
  assign w_seg_nxt = (r_seg == SW'(DAY_LEN - 1)) ? '0 : r_seg + SW'(1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_ciclo <= '0;
      r_seg   <= '0;
      r_dia   <= 1'b0;
    end else if (w_wrap) begin
      r_ciclo <= '0;
      r_seg   <= w_seg_nxt;
      r_dia   <= (w_seg_nxt >= SW'(DAWN_AT)) && (w_seg_nxt < SW'(DUSK_AT));
    end else begin
      r_ciclo <= r_ciclo + CW'(1);
    end
  end

  // Filtered key level flips only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_btn_f  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_btn_s1 <= botao_n;
      r_btn_s2 <= r_btn_s1;
      if (r_btn_s2 == r_btn_f) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE - 1)) begin
        r_btn_f  <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  assign w_ev_man = (r_btn_s2 != r_btn_f) && (r_db_cnt == DW'(DEBOUNCE - 1)) && !r_btn_s2;
  assign w_set    = {w_ev_man,
                     w_wrap && (w_seg_nxt == SW'(DUSK_AT)) && w_sched_ok,
                     w_wrap && (w_seg_nxt == SW'(DAWN_AT)) && w_sched_ok};

  always_comb begin
    w_pick = 3'b000;
    if (r_pend[2])      w_pick = 3'b100;
    else if (r_pend[1]) w_pick = 3'b010;
    else if (r_pend[0]) w_pick = 3'b001;
  end

  assign w_drop     = (r_est == OCIOSO) && (w_pick[1:0] != 2'b00) && irrigando;
  assign w_ack      = r_sel[2] ? (irrigando != r_irr0) : irrigando;
  assign w_tmo      = (r_cnt == TW'(ACK_TIMEOUT - 1));
  assign w_done     = (r_est == ESPERA) && (w_ack || (w_tmo && (r_try == RW'(MAX_RETRY))));
  assign w_clr      = w_drop ? w_pick : (w_done ? r_sel : 3'b000);
  // A manual request is a single-cycle strobe; a longer one would toggle the controller twice.
  assign w_plen_end = (r_cnt == (r_sel[2] ? TW'(1) : TW'(PULSE_LEN)));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_est   <= OCIOSO;
      r_pend  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_try   <= '0;
      r_irr0  <= 1'b0;
      r_am_n  <= 1'b1;
      r_an_n  <= 1'b1;
      r_ct_n  <= 1'b1;
      r_falha <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      case (r_est)
        OCIOSO: begin
          if (w_pick != 3'b000) begin
            r_irr0 <= irrigando;
            if (!w_drop) begin
              r_est                    <= PULSO;
              r_sel                    <= w_pick;
              r_cnt                    <= TW'(1);
              r_try                    <= '0;
              {r_ct_n, r_an_n, r_am_n} <= ~w_pick;
            end
          end
        end
        PULSO: begin
          if (w_plen_end) begin
            r_est                    <= ESPERA;
            r_cnt                    <= '0;
            {r_ct_n, r_an_n, r_am_n} <= 3'b111;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        ESPERA: begin
          if (w_done) begin
            r_est <= OCIOSO;
            if (!w_ack) r_falha <= 1'b1;
          end else if (w_tmo) begin
            r_est                    <= PULSO;
            r_cnt                    <= TW'(1);
            r_try                    <= r_try + RW'(1);
            {r_ct_n, r_an_n, r_am_n} <= ~r_sel;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: r_est <= OCIOSO;
      endcase
    end
  end

  assign amanhecer_n = r_am_n;
  assign anoitecer_n = r_an_n;
  assign controle_n  = r_ct_n;
  assign dia         = r_dia;
  assign falha       = r_falha;
endmodule

// File: tb/tb_jardim_eventos.sv
// Bench for jardim_eventos: directed day/night scenarios plus randomized key presses, with a bench-side controller model.
module tb_jardim_eventos;
  localparam int TPS  = 4;
  localparam int DL   = 8;
  localparam int DAWN = 2;
  localparam int DUSK = 6;
  localparam int PL   = 3;
  localparam int AT   = 10;
  localparam int MR   = 2;
  localparam int DB   = 5;

  logic CLOCK_50  = 1'b0;
  logic reset     = 1'b1;
  logic botao_n   = 1'b1;
  logic irrigando = 1'b0;
  logic amanhecer_n, anoitecer_n, controle_n, dia, falha;
`ifdef JARDIM_EVT_CHUVA_EN
  logic chuva = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int set_at  = -1;
  int tog_at  = -1;
  int overlap = 0;
  bit resp    = 1'b1;
  logic prv [3];
  int run_st [3];
  int starts [3][$];
  int lens [3][$];

  jardim_eventos #(
    .TICKS_PER_SEC(TPS), .DAY_LEN(DL), .DAWN_AT(DAWN), .DUSK_AT(DUSK),
    .PULSE_LEN(PL), .ACK_TIMEOUT(AT), .MAX_RETRY(MR), .DEBOUNCE(DB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .botao_n(botao_n),
    .irrigando(irrigando),
`ifdef JARDIM_EVT_CHUVA_EN
    .chuva(chuva),
`endif
    .amanhecer_n(amanhecer_n),
    .anoitecer_n(anoitecer_n),
    .controle_n(controle_n),
    .dia(dia),
    .falha(falha)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic exp_dia(input int n);
    int s;
    s = (n / TPS) % DL;
    return (s >= DAWN) && (s < DUSK);
  endfunction

  // One clock edge: sample outputs, update controller model, record pulses, check the day flag.
  task automatic tick();
    logic cur [3];
    @(posedge CLOCK_50);
    #1;
    edge_n++;
    cur[0] = amanhecer_n;
    cur[1] = anoitecer_n;
    cur[2] = controle_n;
    if (resp && edge_n == set_at) irrigando = 1'b1;
    if (resp && edge_n == tog_at) irrigando = ~irrigando;
    for (int c = 0; c < 3; c++) begin
      if (!cur[c] && prv[c]) begin
        run_st[c] = edge_n;
        starts[c].push_back(edge_n);
        if (c == 2) tog_at = edge_n + 2;
        else        set_at = edge_n + 2;
      end
      if (cur[c] && !prv[c]) lens[c].push_back(edge_n - run_st[c]);
      prv[c] = cur[c];
    end
    if (int'(!cur[0]) + int'(!cur[1]) + int'(!cur[2]) > 1) overlap++;
    check("dia", dia, exp_dia(edge_n));
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset(input logic irr_init);
    reset     = 1'b1;
    botao_n   = 1'b1;
    irrigando = irr_init;
    resp      = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("rst_amanhecer_n", amanhecer_n, 1);
    check("rst_anoitecer_n", anoitecer_n, 1);
    check("rst_controle_n", controle_n, 1);
    check("rst_dia", dia, 0);
    check("rst_falha", falha, 0);
    @(posedge CLOCK_50);
    #1;
    reset   = 1'b0;
    edge_n  = 0;
    set_at  = -1;
    tog_at  = -1;
    overlap = 0;
    for (int c = 0; c < 3; c++) begin
      prv[c]    = 1'b1;
      run_st[c] = 0;
      starts[c].delete();
      lens[c].delete();
    end
  endtask

  task automatic press(input int lo, input int hi);
    botao_n = 1'b0;
    repeat (lo) tick();
    botao_n = 1'b1;
    repeat (hi) tick();
  endtask

  initial begin
    int lo;
    int exp_man;

    // Responsive controller: one dawn pulse at edges 9-11, dusk dropped while irrigating.
    do_reset(1'b0);
    run_to(8);
    check("s1_dia_at_8", dia, 1);
    run_to(30);
    check("s1_dawn_count", starts[0].size(), 1);
    check("s1_dawn_start", starts[0][0], 9);
    check("s1_dawn_len", lens[0][0], 3);
    check("s1_dusk_count", starts[1].size(), 0);
    check("s1_falha", falha, 0);
    check("s1_overlap", overlap, 0);

    // irrigando tied low: three dawn sends, then falha, dusk still attempted.
    do_reset(1'b0);
    resp = 1'b0;
    while (edge_n < 80) begin
      tick();
      if (edge_n == 47) check("s2_falha_before", falha, 0);
      if (edge_n == 48) check("s2_falha_set", falha, 1);
    end
    check("s2_dawn_count", starts[0].size(), 3);
    check("s2_dawn_start0", starts[0][0], 9);
    check("s2_dawn_start1", starts[0][1], 22);
    check("s2_dawn_start2", starts[0][2], 35);
    for (int i = 0; i < 3; i++) check("s2_dawn_len", lens[0][i], 3);
    check("s2_dusk_start0", starts[1][0], 49);
    check("s2_dusk_start1", starts[1][1], 62);
    check("s2_falha_sticky", falha, 1);
    check("s2_overlap", overlap, 0);

    // Controller starts irrigating; press toggles it off, second press lands on the dusk edge.
    do_reset(1'b1);
    run_to(34);
    botao_n = 1'b0;
    run_to(40);
    botao_n = 1'b1;
    run_to(49);
    botao_n = 1'b0;
    run_to(70);
    botao_n = 1'b1;
    run_to(75);
    check("s4_man_count", starts[2].size(), 2);
    check("s4_man_start0", starts[2][0], 42);
    check("s4_man_start1", starts[2][1], 57);
    check("s4_dusk_dropped", starts[1].size(), 0);
    check("s4_dawn_dropped", starts[0].size(), 0);
    check("s4_falha", falha, 0);

    // Key filter: glitches ignored, one strobe per accepted press, randomized press lengths.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) press($urandom_range(1, DB - 1), $urandom_range(6, 12));
    check("s3_glitch_none", starts[2].size(), 0);
    press(8, 20);
    check("s3_press8_count", starts[2].size(), 1);
    check("s3_press8_len", lens[2][0], 1);
    press(40, 20);
    check("s3_hold40_count", starts[2].size(), 2);
    exp_man = 2;
    for (int i = 0; i < 10; i++) begin
      lo = $urandom_range(1, 12);
      if (lo >= DB) exp_man++;
      press(lo, $urandom_range(20, 35));
    end
    repeat (20) tick();
    check("s3_rand_count", starts[2].size(), exp_man);
    for (int i = 0; i < lens[2].size(); i++) check("s3_strobe_len", lens[2][i], 1);
    check("s3_falha", falha, 0);
    check("s3_overlap", overlap, 0);

    // Reset mid-pulse clears outputs asynchronously and restarts the day.
    do_reset(1'b0);
    run_to(10);
    check("s5_pulse_low", amanhecer_n, 0);
    reset = 1'b1;
    #1;
    check("s5_async_amanhecer_n", amanhecer_n, 1);
    check("s5_async_dia", dia, 0);
    check("s5_async_falha", falha, 0);
    do_reset(1'b0);
    run_to(7);
    check("s5_dia_at_7", dia, 0);
    run_to(8);
    check("s5_dia_at_8", dia, 1);

`ifdef JARDIM_EVT_CHUVA_EN
    // Rain across dawn suppresses it; dry dusk goes out normally.
    chuva = 1'b1;
    do_reset(1'b0);
    run_to(15);
    chuva = 1'b0;
    run_to(30);
    check("s6_dawn_rain", starts[0].size(), 0);
    check("s6_dusk_count", starts[1].size(), 1);
    check("s6_dusk_start", starts[1][0], 25);
    check("s6_dusk_len", lens[1][0], 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jardim_eventos.md
Name: jardim_eventos

Overview:
- Event source for the garden irrigation controller: generates its active-low dawn, dusk and manual-control inputs from a scaled day/night timer and a debounced manual key.
- Uses the controller's "irrigating" indication (green LED line) as acknowledge; re-sends unacknowledged events and flags persistent failure.
- Sits between board pins (CLOCK_50, raw KEY) and the controller inputs, replacing direct KEY wiring.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per simulated second.
- DAY_LEN, 24, seconds per simulated day; second counter wraps DAY_LEN-1 -> 0.
- DAWN_AT, 6, second value that triggers a dawn event (0 <= DAWN_AT < DUSK_AT < DAY_LEN).
- DUSK_AT, 18, second value that triggers a dusk event.
- PULSE_LEN, 3, cycles amanhecer_n/anoitecer_n are held low per send (>=1).
- ACK_TIMEOUT, 100, cycles to wait for acknowledge after a pulse ends.
- MAX_RETRY, 2, re-sends after the first attempt before giving up.
- DEBOUNCE, 1000000, cycles botao_n must be stable to be accepted.

Ports:
- CLOCK_50 in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- botao_n in 1: raw manual key, active-low, asynchronous, bouncy.
- irrigando in 1: controller irrigation-active feedback (1 = on).
- amanhecer_n out 1: dawn request to controller, active-low.
- anoitecer_n out 1: dusk request, active-low.
- controle_n out 1: manual toggle request, active-low.
- dia out 1: 1 while DAWN_AT <= seg < DUSK_AT.
- falha out 1: sticky; event never acknowledged.

Behaviour:
- Reset (async, any cycle including mid-pulse): amanhecer_n = anoitecer_n = controle_n = 1, dia = 0, falha = 0, all counters, pending bits and sync/debounce state cleared, FSM = OCIOSO. All outputs registered.
- Timer: ciclo counts 0..TICKS_PER_SEC-1. The wrap edge increments seg (wraps at DAY_LEN). When seg changes to DAWN_AT, set pend_dawn; when it changes to DUSK_AT, set pend_dusk, on that same edge. dia is updated on the same edge as seg.
- Manual key: 2-FF synchroniser, then a counter requiring DEBOUNCE consecutive equal samples before the filtered level changes. A filtered 1->0 transition sets pend_man once per press. Release does nothing.
- Pending bits merge: an event already pending is not queued twice.
- Priority at arbitration: man > dusk > dawn.
- FSM states:
  - OCIOSO: if any pending bit is set, pick the highest priority and latch irr0 = irrigando.
    - Dawn/dusk picked while irrigando = 1: clear the bit, send nothing, stay OCIOSO.
    - Otherwise go to PULSO on the next edge, with the output low from that edge.
  - PULSO: dawn/dusk output held low exactly PULSE_LEN cycles. controle_n is low exactly 1 cycle, because a longer low would toggle the controller twice. Then go to ESPERA.
  - ESPERA: up to ACK_TIMEOUT cycles.
    - Acknowledge condition: irrigando = 1 for dawn/dusk; irrigando != irr0 for manual.
    - On acknowledge: clear the serviced pending bit and go to OCIOSO.
    - On timeout with retries left: increment retry count and go to PULSO.
    - On timeout after MAX_RETRY re-sends: set falha, clear the bit, go to OCIOSO.
- Events arriving during PULSO/ESPERA set pending bits and are served afterwards.
- Latency: event edge N -> output low at edge N+1 when the FSM is idle.
- At most one output is low at any time.

Optional Feature:
- Macro JARDIM_EVT_CHUVA_EN.
- When defined: adds input port chuva (1 bit, active-high rain sensor, 2-FF synchronised).
  - Dawn/dusk events occurring while synchronised chuva = 1 are discarded (pending bit not set).
  - Manual events are unaffected.
- When undefined: the port does not exist and all scheduled events are issued.

Test Plan:
All scenarios use TICKS_PER_SEC=4, DAY_LEN=8, DAWN_AT=2, DUSK_AT=6, PULSE_LEN=3, ACK_TIMEOUT=10, MAX_RETRY=2, DEBOUNCE=5. The bench controller model raises irrigando 2 cycles after amanhecer_n/anoitecer_n goes low, unless a scenario says otherwise.
- Reset release, model responsive -> seg=2 at edge 8, dia=1; amanhecer_n low edges 9-11 only; no re-send; falha=0.
- irrigando tied 0 -> 3 amanhecer_n pulses of 3 cycles, each pulse followed by 10-cycle wait; then falha=1 and stays 1 through the dusk attempt.
- botao_n glitches low 1-4 cycles -> no controle_n. Stable low 8 cycles -> exactly one 1-cycle controle_n low. Held low 40 cycles -> still one.
- Debounced press lands on the dusk edge with irrigando=0 -> controle_n first. Model turns irrigation on, so dusk is dropped with no anoitecer_n pulse.
- reset asserted during 2nd cycle of amanhecer_n pulse -> amanhecer_n=1 before next clock edge, dia=0, seg=0.
- JARDIM_EVT_CHUVA_EN defined, chuva=1 across DAWN_AT -> no amanhecer_n. chuva=0 at DUSK_AT -> anoitecer_n pulses normally.
